// File: rtl/music_sequencer.sv
// music_sequencer
//
// Step sequencer for the music feature path. Plays a small programmable
// pattern of notes: each step sets the tone clock divisor, the octave
// up/down mode (or a rest) and the tremolo and LED enables. Steps last
// a programmable tempo, may be followed by a silent gap, and the
// pattern can loop.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   cfg_we/addr/data      pattern entry write: [11:0] divisor,
//                         [13:12] mode (00 plain, 01 oct down, 10 oct up,
//                         11 rest), [14] tremolo, [15] led
//   tempo                 clk cycles per step (0 behaves as 1)
//   gap                   silent clk cycles after each step
//   loop                  wrap to step 0 after the last step
//   start, stop           playback control pulses (stop has priority)
//   busy, step_idx, done  playback status; done pulses on normal completion
//   tone_clk, trem_clk    square waves to the feature block clk1 / clk2
//   octave_dena/uena, tremolo_ena, led_ena   registered per-step enables
//
// Optional build macro SEQ_SWING_EN: odd-indexed steps play
// tempo + tempo/4 cycles instead of tempo cycles.

module music_sequencer #(
  parameter int STEPS    = 8,
  parameter int TEMPO_W  = 16,
  parameter int DIV_W    = 12,
  parameter int TREM_DIV = 2047
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [$clog2(STEPS)-1:0] cfg_addr,
  input  logic [15:0]              cfg_data,
  input  logic [TEMPO_W-1:0]       tempo,
  input  logic [7:0]               gap,
  input  logic                     loop,
  input  logic                     start,
  input  logic                     stop,
  output logic                     busy,
  output logic [$clog2(STEPS)-1:0] step_idx,
  output logic                     done,
  output logic                     tone_clk,
  output logic                     trem_clk,
  output logic                     octave_dena,
  output logic                     octave_uena,
  output logic                     tremolo_ena,
  output logic                     led_ena
);

  localparam int AW = $clog2(STEPS);
  localparam int TW = $clog2(TREM_DIV + 2);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t             state_reg, state_next;
  logic [15:0]        pattern_mem [STEPS];
  logic [15:0]        entry_reg;
  logic [AW-1:0]      step_reg;
  logic [TEMPO_W:0]   tempo_cnt_reg;   // counts down from step length to 1
  logic [7:0]         gap_cnt_reg;     // counts down from gap to 1
  logic [DIV_W-1:0]   tone_cnt_reg;
  logic               tone_reg;
  logic [TW-1:0]      trem_cnt_reg;
  logic               trem_reg;
  logic               done_reg;
  logic               oct_d_reg, oct_u_reg, trem_en_reg, led_reg;

  // Control decoded from the FSM
  logic               load;       // load a step (from IDLE or on advance)
  logic               finish;     // normal completion after the last step
  logic               enter_gap;
  logic               last_step;
  logic [AW-1:0]      load_idx;
  logic [15:0]        load_entry;
  logic [TEMPO_W-1:0] tempo_eff;
  logic [TEMPO_W:0]   step_len;
  logic               play_rest;
  logic [DIV_W-1:0]   tone_div;

  assign last_step = (step_reg == AW'(STEPS - 1));
  assign play_rest = (entry_reg[13:12] == 2'b11);
  assign tone_div  = entry_reg[DIV_W-1:0];

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    finish     = 1'b0;
    enter_gap  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && !stop) begin
          load       = 1'b1;
          state_next = PLAY;
        end
      end
      PLAY: begin
        if (stop) begin
          state_next = IDLE;
        end else if (tempo_cnt_reg == (TEMPO_W+1)'(1)) begin
          if (gap != 8'd0) begin
            enter_gap  = 1'b1;
            state_next = GAP;
          end else if (last_step && !loop) begin
            finish     = 1'b1;
            state_next = IDLE;
          end else begin
            load       = 1'b1;
            state_next = PLAY;
          end
        end
      end
      GAP: begin
        if (stop) begin
          state_next = IDLE;
        end else if (gap_cnt_reg == 8'd1) begin
          if (last_step && !loop) begin
            finish     = 1'b1;
            state_next = IDLE;
          end else begin
            load       = 1'b1;
            state_next = PLAY;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Step to load: step 0 from IDLE, otherwise the following step
  // (wrapping after the last one when looping).
  always_comb begin
    load_idx   = '0;
    if (state_reg != IDLE && !last_step) begin
      load_idx = step_reg + 1'b1;
    end
    // Read before this cycle's write lands, so a same-cycle write to the
    // loaded entry is only heard on the next visit.
    load_entry = pattern_mem[load_idx];
    tempo_eff  = (tempo == '0) ? TEMPO_W'(1) : tempo;
`ifdef SEQ_SWING_EN
    step_len   = {1'b0, tempo_eff} +
                 (load_idx[0] ? {3'b000, tempo_eff[TEMPO_W-1:2]} : '0);
`else
    step_len   = {1'b0, tempo_eff};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      for (int i = 0; i < STEPS; i++) pattern_mem[i] <= '0;
      entry_reg     <= '0;
      step_reg      <= '0;
      tempo_cnt_reg <= '0;
      gap_cnt_reg   <= '0;
      tone_cnt_reg  <= '0;
      tone_reg      <= 1'b0;
      trem_cnt_reg  <= '0;
      trem_reg      <= 1'b0;
      done_reg      <= 1'b0;
      oct_d_reg     <= 1'b0;
      oct_u_reg     <= 1'b0;
      trem_en_reg   <= 1'b0;
      led_reg       <= 1'b0;
    end else begin
      if (cfg_we) pattern_mem[cfg_addr] <= cfg_data;

      state_reg <= state_next;
      done_reg  <= finish;

      if (load) begin
        step_reg      <= load_idx;
        entry_reg     <= load_entry;
        tempo_cnt_reg <= step_len;
        tone_cnt_reg  <= '0;
        tone_reg      <= 1'b0;
        oct_d_reg     <= (load_entry[13:12] == 2'b01);
        oct_u_reg     <= (load_entry[13:12] == 2'b10);
        trem_en_reg   <= load_entry[14] && (load_entry[13:12] != 2'b11);
        led_reg       <= load_entry[15] && (load_entry[13:12] != 2'b11);
      end else if (state_next != PLAY) begin
        // GAP or IDLE: silence everything
        tone_cnt_reg  <= '0;
        tone_reg      <= 1'b0;
        oct_d_reg     <= 1'b0;
        oct_u_reg     <= 1'b0;
        trem_en_reg   <= 1'b0;
        led_reg       <= 1'b0;
        if (state_next == IDLE) begin
          step_reg      <= '0;
          tempo_cnt_reg <= '0;
        end
      end else begin
        tempo_cnt_reg <= tempo_cnt_reg - 1'b1;
        // A zero divisor or a rest keeps the tone low.
        if (play_rest || tone_div == '0) begin
          tone_reg <= 1'b0;
        end else if (tone_cnt_reg == tone_div) begin
          tone_cnt_reg <= '0;
          tone_reg     <= ~tone_reg;
        end else begin
          tone_cnt_reg <= tone_cnt_reg + 1'b1;
        end
      end

      if (state_next == IDLE) begin
        gap_cnt_reg <= '0;
      end else if (enter_gap) begin
        gap_cnt_reg <= gap;
      end else if (state_reg == GAP) begin
        gap_cnt_reg <= gap_cnt_reg - 1'b1;
      end

      // Tremolo clock runs only while playing; it restarts from zero at
      // each start so its phase is fixed relative to the first step.
      if (state_reg == IDLE || state_next == IDLE) begin
        trem_cnt_reg <= '0;
        trem_reg     <= 1'b0;
      end else if (trem_cnt_reg == TW'(TREM_DIV)) begin
        trem_cnt_reg <= '0;
        trem_reg     <= ~trem_reg;
      end else begin
        trem_cnt_reg <= trem_cnt_reg + 1'b1;
      end
    end
  end

  assign busy        = (state_reg != IDLE);
  assign step_idx    = step_reg;
  assign done        = done_reg;
  assign tone_clk    = tone_reg;
  assign trem_clk    = trem_reg;
  assign octave_dena = oct_d_reg;
  assign octave_uena = oct_u_reg;
  assign tremolo_ena = trem_en_reg;
  assign led_ena     = led_reg;

endmodule

// File: doc/music_sequencer.md
Name: music_sequencer

Overview:
- Step sequencer that drives the music feature path: tone clock (clk1 side), tremolo clock (clk2 side), and per-step enables for octave-down, octave-up, tremolo and LED chase.
- Plays a small programmable pattern of notes at a programmable tempo, with optional silent gaps and looping.
- Sits between the tt top-level config pins and the music feature block.

Parameters:
- STEPS, 8, number of pattern entries (power of two, 2..16).
- TEMPO_W, 16, width of the tempo counter (cycles per step).
- DIV_W, 12, width of the tone half-period divisor.
- TREM_DIV, 2047, tremolo clock half-period minus 1, in clk cycles.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- cfg_we, input, 1, pattern write strobe.
- cfg_addr, input, clog2(STEPS), pattern entry index.
- cfg_data, input, 16, entry bits:
  - [11:0] divisor (DIV_W).
  - [13:12] mode: 00 plain, 01 octave down, 10 octave up, 11 rest.
  - [14] tremolo.
  - [15] led.
- tempo, input, TEMPO_W, clk cycles per note step.
- gap, input, 8, silent clk cycles between steps.
- loop, input, 1, restart at step 0 after last step.
- start, input, 1, begin playback (pulse).
- stop, input, 1, abort playback (pulse).
- busy, output, 1, high in PLAY or GAP.
- step_idx, output, clog2(STEPS), current step.
- done, output, 1, one-cycle pulse at normal completion.
- tone_clk, output, 1, square wave to feature block clk1.
- trem_clk, output, 1, square wave to feature block clk2.
- octave_dena, output, 1, registered.
- octave_uena, output, 1, registered.
- tremolo_ena, output, 1, registered.
- led_ena, output, 1, registered.

Behaviour:
- Clocking and reset:
  - Single clock, clk.
  - Synchronous active-high reset rst: state IDLE, all pattern entries 0, all counters 0.
  - Every output is 0 on reset.
  - rst mid-playback returns to IDLE on the next edge, with no done pulse.
- Pattern writes:
  - cfg_we writes an entry in any state; the entry is visible the following cycle.
  - The active step's entry is latched at step load, so writes to the playing step take effect only on its next visit.
- FSM states: IDLE, PLAY, GAP.
- IDLE:
  - busy=0, all enables 0, tone_clk=0.
  - start -> load step 0, enter PLAY next cycle.
- PLAY:
  - tempo counter counts latched tempo cycles; tempo==0 is treated as 1.
  - Latched entry drives enables:
    - mode 01 -> octave_dena=1.
    - mode 10 -> octave_uena=1.
    - mode 11 -> rest: all enables 0, tone_clk held 0.
    - tremolo_ena = bit14; led_ena = bit15.
  - Tone divider: tone_clk toggles every divisor+1 cycles. divisor==0 holds tone_clk at 0. The divider restarts at 0 at each step load.
  - At step end:
    - gap!=0 -> GAP.
    - gap==0 -> advance directly.
- GAP:
  - All enables 0, tone_clk=0, for exactly gap cycles, then advance.
- Advance:
  - step_idx < STEPS-1 -> step_idx+1, reload, PLAY.
  - Last step with loop=1 -> wrap to 0, PLAY.
  - Last step with loop=0 -> done=1 for one cycle, IDLE.
- trem_clk:
  - Free-running; toggles every TREM_DIV+1 cycles while busy.
  - Held 0 and counter cleared in IDLE.
- Simultaneous events:
  - start while busy is ignored.
  - stop in PLAY/GAP -> IDLE next cycle, with no done pulse.
  - stop and start in the same cycle -> stop wins.
  - cfg_we and step load of the same entry in the same cycle -> the old value is loaded.
- Latency: start at edge N -> busy=1 and step 0 enables valid at edge N+1.
- Step length is exactly tempo cycles in PLAY plus gap cycles in GAP.

Optional Feature:
- Macro: SEQ_SWING_EN.
- Defined: odd-indexed steps play tempo + (tempo>>2) cycles in PLAY; even steps play tempo cycles. Adds a swing rhythm.
- Undefined: all steps play exactly tempo cycles, and no swing logic is synthesised.

Test Plan:
- Reset, then idle 10 cycles -> all outputs 0, busy=0, step_idx=0.
- Program entry 0 = 0x0003 (div 3, plain), entry 1 = 0x1005 (octave down); STEPS=2, tempo=16, gap=0, loop=0; start:
  - step 0 for 16 cycles with tone_clk period 8.
  - step 1 for 16 cycles with octave_dena=1 and tone_clk period 12.
  - done pulse at cycle 33; busy then 0.
- Entry 0 = 0xC000 (tremolo+LED, div 0), gap=4, loop=1 -> tone_clk stays 0; tremolo_ena=led_ena=1 for tempo cycles, then 0 for 4 cycles; step_idx wraps 1->0; no done pulse.
- Mode 11 rest step -> all enables 0 and tone_clk 0 for the whole step; step_idx still advances.
- Assert stop and start together mid-PLAY -> IDLE next cycle, no done pulse; a later start replays from step 0.
- Write the active entry during PLAY -> current step unchanged; new value heard on the next loop. With SEQ_SWING_EN and tempo=16, step 1 lasts 20 cycles.
